// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller: FSM states, counter
// widths and the per-cycle control vector driven onto the pipeline registers.
package pipeline_ctrl_pkg;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int MEM_TIMEOUT_DEF  = 15;
  localparam int DRAIN_W          = 3;
  localparam int WAIT_W           = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  // Write enables are active-low: 0 loads the register, 1 holds it.
  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic id_ex_wen;
    logic ex_mem_wen;
    logic mem_wb_wen;
    logic valid_if;
    logic kill_id;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_wen: 1'b0, if_id_wen: 1'b0, id_ex_wen: 1'b0,
                                 ex_mem_wen: 1'b0, mem_wb_wen: 1'b0,
                                 valid_if: 1'b1, kill_id: 1'b0};

  localparam ctrl_t CTRL_STALL = '{pc_wen: 1'b1, if_id_wen: 1'b1, id_ex_wen: 1'b1,
                                   ex_mem_wen: 1'b1, mem_wb_wen: 1'b1,
                                   valid_if: 1'b1, kill_id: 1'b0};

  localparam ctrl_t CTRL_REDIRECT = '{pc_wen: 1'b0, if_id_wen: 1'b0, id_ex_wen: 1'b0,
                                      ex_mem_wen: 1'b0, mem_wb_wen: 1'b0,
                                      valid_if: 1'b0, kill_id: 1'b1};

  localparam ctrl_t CTRL_LOAD_USE = '{pc_wen: 1'b1, if_id_wen: 1'b1, id_ex_wen: 1'b0,
                                      ex_mem_wen: 1'b0, mem_wb_wen: 1'b0,
                                      valid_if: 1'b1, kill_id: 1'b1};

  localparam ctrl_t CTRL_HOLD = '{pc_wen: 1'b1, if_id_wen: 1'b1, id_ex_wen: 1'b1,
                                  ex_mem_wen: 1'b1, mem_wb_wen: 1'b1,
                                  valid_if: 1'b0, kill_id: 1'b0};

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard detector: an EX-stage load whose destination
// is a source actually read by the instruction in ID.
module pipe_hazard_detect (
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rdst_ex,
  input  logic       RWrEn_ex,
  input  logic       load_ex,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1_id & (rs1_id == rdst_ex);
  assign rs2_hit = use_rs2_id & (rs2_id == rdst_ex);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = load_ex & ~RWrEn_ex & (rdst_ex != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller: prioritises halt, memory stalls,
// redirects and load-use hazards; drains the pipe after a halt and times out memory.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rdst_ex,
  input  logic       RWrEn_ex,
  input  logic       load_ex,
  input  logic       redirect_ex,
  input  logic       halt_id,
  input  logic       mem_req_mem,
  input  logic       mem_ready,
  output logic       pc_WEN,
  output logic       if_id_WEN,
  output logic       id_ex_WEN,
  output logic       ex_mem_WEN,
  output logic       mem_wb_WEN,
  output logic       valid_if,
  output logic       kill_id,
  output logic       halted,
  output logic       mem_err
);

  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

  state_t             state,      state_nx;
  logic [DRAIN_W-1:0] drain_cnt,  drain_nx;
  logic [WAIT_W-1:0]  wait_cnt,   wait_nx;
  logic               mem_err_q,  mem_err_nx;
  logic               ld_stall_q, ld_stall_nx;
  logic               load_use_raw;
  logic               load_use;
  logic               mem_stall;
  ctrl_t              ctrl;

  pipe_hazard_detect u_hazard (
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .rdst_ex    (rdst_ex),
    .RWrEn_ex   (RWrEn_ex),
    .load_ex    (load_ex),
    .load_use   (load_use_raw)
  );

  // After one bubble the load has moved to MEM, so a repeat match is stale.
  assign load_use  = load_use_raw & ~ld_stall_q;
  assign mem_stall = mem_req_mem & ~mem_ready;

  // State advances on the falling edge, in step with the pipeline registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      wait_cnt   <= '0;
      mem_err_q  <= 1'b0;
      ld_stall_q <= 1'b0;
    end else begin
      state      <= state_nx;
      drain_cnt  <= drain_nx;
      wait_cnt   <= wait_nx;
      mem_err_q  <= mem_err_nx;
      ld_stall_q <= ld_stall_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl        = CTRL_RUN;
    state_nx    = state;
    drain_nx    = drain_cnt;
    wait_nx     = '0;
    mem_err_nx  = mem_err_q;
    ld_stall_nx = 1'b0;

    if (state != ST_HALTED && mem_stall) begin
      wait_nx = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl = CTRL_STALL;
        end else if (redirect_ex) begin
          ctrl = CTRL_REDIRECT;
        end else if (load_use) begin
          ctrl        = CTRL_LOAD_USE;
          ld_stall_nx = 1'b1;
        end else if (halt_id) begin
          state_nx = ST_DRAIN;
          drain_nx = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (mem_stall) begin
          ctrl = CTRL_STALL;
        end else if (drain_cnt <= DRAIN_W'(1)) begin
          state_nx = ST_HALTED;
          drain_nx = '0;
        end else begin
          drain_nx = drain_cnt - 1'b1;
        end
        ctrl.pc_wen   = 1'b1;
        ctrl.valid_if = 1'b0;
      end
      ST_HALTED: ctrl = CTRL_HOLD;
      default: begin
        ctrl     = CTRL_HOLD;
        state_nx = ST_RUN;
      end
    endcase

    // A memory timeout overrides everything and parks the pipeline.
    if (wait_nx == WAIT_MAX) begin
      mem_err_nx = 1'b1;
      state_nx   = ST_HALTED;
    end

    if (RST) ctrl = CTRL_HOLD;
  end

  assign pc_WEN     = ctrl.pc_wen;
  assign if_id_WEN  = ctrl.if_id_wen;
  assign id_ex_WEN  = ctrl.id_ex_wen;
  assign ex_mem_WEN = ctrl.ex_mem_wen;
  assign mem_wb_WEN = ctrl.mem_wb_wen;
  assign valid_if   = ctrl.valid_if;
  assign kill_id    = ctrl.kill_id;
  assign halted     = (state == ST_HALTED);
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each stimulus cycle pushes its expected
// output vector, and a monitor pops and compares it mid-cycle before the falling edge.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rdst;
    logic       use1;
    logic       use2;
    logic       rwren;
    logic       load;
    logic       redirect;
    logic       halt;
    logic       memreq;
    logic       memready;
  } stim_t;

  // {pc, if_id, id_ex, ex_mem, mem_wb WEN, valid_if, kill_id, halted, mem_err}
  localparam logic [8:0] E_RUN    = 9'b00000_1_0_0_0;
  localparam logic [8:0] E_STALL  = 9'b11111_1_0_0_0;
  localparam logic [8:0] E_REDIR  = 9'b00000_0_1_0_0;
  localparam logic [8:0] E_LU     = 9'b11000_1_1_0_0;
  localparam logic [8:0] E_DRAIN  = 9'b10000_0_0_0_0;
  localparam logic [8:0] E_DSTALL = 9'b11111_0_0_0_0;
  localparam logic [8:0] E_HALT   = 9'b11111_0_0_1_0;
  localparam logic [8:0] E_TOUT   = 9'b11111_0_0_1_1;
  localparam logic [8:0] E_RST    = 9'b11111_0_0_0_0;

  logic       CLK = 1'b1;
  logic       RST;
  logic [4:0] rs1_id, rs2_id, rdst_ex;
  logic       use_rs1_id, use_rs2_id, RWrEn_ex, load_ex;
  logic       redirect_ex, halt_id, mem_req_mem, mem_ready;
  logic       pc_WEN, if_id_WEN, id_ex_WEN, ex_mem_WEN, mem_wb_WEN;
  logic       valid_if, kill_id, halted, mem_err;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  pipeline_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .use_rs1_id  (use_rs1_id),
    .use_rs2_id  (use_rs2_id),
    .rdst_ex     (rdst_ex),
    .RWrEn_ex    (RWrEn_ex),
    .load_ex     (load_ex),
    .redirect_ex (redirect_ex),
    .halt_id     (halt_id),
    .mem_req_mem (mem_req_mem),
    .mem_ready   (mem_ready),
    .pc_WEN      (pc_WEN),
    .if_id_WEN   (if_id_WEN),
    .id_ex_WEN   (id_ex_WEN),
    .ex_mem_WEN  (ex_mem_WEN),
    .mem_wb_WEN  (mem_wb_WEN),
    .valid_if    (valid_if),
    .kill_id     (kill_id),
    .halted      (halted),
    .mem_err     (mem_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] outs();
    return {pc_WEN, if_id_WEN, id_ex_WEN, ex_mem_WEN, mem_wb_WEN,
            valid_if, kill_id, halted, mem_err};
  endfunction

  task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, act, exp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s          = '0;
    s.rwren    = 1'b1;
    s.memready = 1'b1;
    return s;
  endfunction

  function automatic stim_t lu();
    stim_t s;
    s       = idle();
    s.load  = 1'b1;
    s.rwren = 1'b0;
    s.rdst  = 5'd5;
    s.rs2   = 5'd5;
    s.use2  = 1'b1;
    return s;
  endfunction

  function automatic stim_t mstall();
    stim_t s;
    s          = idle();
    s.memreq   = 1'b1;
    s.memready = 1'b0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rs1_id      = s.rs1;
    rs2_id      = s.rs2;
    rdst_ex     = s.rdst;
    use_rs1_id  = s.use1;
    use_rs2_id  = s.use2;
    RWrEn_ex    = s.rwren;
    load_ex     = s.load;
    redirect_ex = s.redirect;
    halt_id     = s.halt;
    mem_req_mem = s.memreq;
    mem_ready   = s.memready;
  endtask

  task automatic apply(input stim_t s, input logic [8:0] e, input string tag);
    @(posedge CLK);
    #1;
    drive(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Reset pulse placed between falling edges, outputs checked while it is high.
  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1 check(tag, outs(), E_RST);
    #1 RST = 1'b0;
  endtask

  initial begin : monitor
    logic [8:0] e;
    string      t;
    forever begin
      @(posedge CLK);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, outs(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    stim_t s;
    RST = 1'b1;
    drive(idle());
    #2 check("reset_outputs", outs(), E_RST);
    @(posedge CLK);
    #2 RST = 1'b0;

    apply(idle(), E_RUN, "idle");

    // Load-use on rs2: single bubble, a stale repeat does not stall again.
    apply(lu(), E_LU, "lu_rs2");
    apply(lu(), E_RUN, "lu_one_cycle");
    apply(idle(), E_RUN, "after_lu");

    s = idle(); s.load = 1'b1; s.rwren = 1'b0; s.rdst = 5'd7; s.rs1 = 5'd7; s.use1 = 1'b1;
    apply(s, E_LU, "lu_rs1");
    apply(idle(), E_RUN, "after_lu_rs1");

    s = lu(); s.use2 = 1'b0;
    apply(s, E_RUN, "lu_src_unused");
    s = lu(); s.rwren = 1'b1;
    apply(s, E_RUN, "lu_no_write");
    s = lu(); s.load = 1'b0;
    apply(s, E_RUN, "lu_not_load");
    s = lu(); s.rdst = 5'd0; s.rs2 = 5'd0;
    apply(s, E_RUN, "lu_x0");

    s = lu(); s.redirect = 1'b1;
    apply(s, E_REDIR, "redirect_over_lu");
    apply(idle(), E_RUN, "after_redirect");

    // Stall beats redirect; the held redirect is then honoured.
    s = mstall(); s.redirect = 1'b1;
    apply(s, E_STALL, "stall_over_redirect");
    s = idle(); s.redirect = 1'b1;
    apply(s, E_REDIR, "redirect_replayed");

    // Halts that must not start a drain.
    s = idle(); s.halt = 1'b1; s.redirect = 1'b1;
    apply(s, E_REDIR, "halt_wrong_path");
    apply(idle(), E_RUN, "no_drain_1");
    apply(idle(), E_RUN, "no_drain_2");
    s = lu(); s.halt = 1'b1;
    apply(s, E_LU, "halt_with_lu");
    apply(idle(), E_RUN, "no_drain_lu");
    s = mstall(); s.halt = 1'b1;
    apply(s, E_STALL, "halt_with_stall");
    apply(idle(), E_RUN, "no_drain_stall");

    // Drain: 4 advancing + 2 stalled cycles, halted after the 6th edge.
    s = idle(); s.halt = 1'b1;
    apply(s, E_RUN, "halt_accept");
    apply(idle(), E_DRAIN, "drain_1");
    apply(mstall(), E_DSTALL, "drain_stall_1");
    apply(mstall(), E_DSTALL, "drain_stall_2");
    apply(idle(), E_DRAIN, "drain_2");
    apply(idle(), E_DRAIN, "drain_3");
    apply(idle(), E_DRAIN, "drain_4");
    apply(idle(), E_HALT, "halted");
    apply(mstall(), E_HALT, "halted_stall");
    s = lu(); s.redirect = 1'b1;
    apply(s, E_HALT, "halted_sticky");

    pulse_reset("reset_from_halted");
    apply(idle(), E_RUN, "run_after_reset");

    // Reset mid-drain abandons it.
    s = idle(); s.halt = 1'b1;
    apply(s, E_RUN, "halt_accept_2");
    apply(idle(), E_DRAIN, "drain_again");
    pulse_reset("reset_mid_drain");
    for (int i = 0; i < 5; i++) apply(idle(), E_RUN, "drain_abandoned");

    // Wait counter clears on a ready cycle and on reset.
    for (int i = 0; i < 14; i++) apply(mstall(), E_STALL, "stall_14");
    apply(idle(), E_RUN, "stall_released");
    for (int i = 0; i < 10; i++) apply(mstall(), E_STALL, "stall_pre_reset");
    pulse_reset("reset_mid_stall");
    for (int i = 0; i < 14; i++) apply(mstall(), E_STALL, "stall_post_reset");
    apply(idle(), E_RUN, "stall_post_reset_done");

    // Timeout after 15 stalled cycles; mem_err and halted stay until reset.
    for (int i = 0; i < 15; i++) apply(mstall(), E_STALL, "timeout_wait");
    apply(mstall(), E_TOUT, "timeout_hit");
    apply(idle(), E_TOUT, "timeout_sticky");
    pulse_reset("reset_after_timeout");
    apply(idle(), E_RUN, "run_after_timeout");

    @(posedge CLK);
    #5;
    check("scoreboard_empty", 9'(exp_q.size()), 9'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
